// File: rtl/seg7_bus_display.sv
// Bus-mapped multiplexed seven-segment controller with per-digit data, CTRL and DPMASK registers.
// Optional blinking (BLINKMASK register and blink phase) is enabled by defining SEG7_BLINK_EN.
module seg7_bus_display #(
  parameter int         NUM_DIGITS  = 4,
  parameter logic [7:0] BASE_ADDR   = 8'hD0,
  parameter int         REFRESH_DIV = 100000,
  parameter bit         ACTIVE_LOW  = 1'b1
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  BUS_WE,
  input  logic [7:0]            BUS_ADDR,
  input  logic [7:0]            BUS_DATA,
  output logic [NUM_DIGITS-1:0] SEL,
  output logic [7:0]            DIGIT
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam logic [CW-1:0] CNT_LAST  = CW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);
  localparam logic [7:0]    CTRL_ADDR = BASE_ADDR + 8'(NUM_DIGITS);
  localparam logic [7:0]    DP_ADDR   = BASE_ADDR + 8'(NUM_DIGITS + 1);

  logic [7:0]            data_r [NUM_DIGITS];
  logic [7:0]            ctrl_r;
  logic [7:0]            dpmask_r;
  logic [CW-1:0]         cnt;
  logic [IW-1:0]         idx;
  logic [7:0]            cur;
  logic [6:0]            seg;
  logic [7:0]            digit_next;
  logic [NUM_DIGITS-1:0] sel_next;
  logic                  cnt_wrap;
  logic                  unused_bits;

  function automatic logic [6:0] hex_decode(input logic [3:0] nib);
    case (nib)
      4'h0: hex_decode = 7'h3F;
      4'h1: hex_decode = 7'h06;
      4'h2: hex_decode = 7'h5B;
      4'h3: hex_decode = 7'h4F;
      4'h4: hex_decode = 7'h66;
      4'h5: hex_decode = 7'h6D;
      4'h6: hex_decode = 7'h7D;
      4'h7: hex_decode = 7'h07;
      4'h8: hex_decode = 7'h7F;
      4'h9: hex_decode = 7'h6F;
      4'hA: hex_decode = 7'h77;
      4'hB: hex_decode = 7'h7C;
      4'hC: hex_decode = 7'h39;
      4'hD: hex_decode = 7'h5E;
      4'hE: hex_decode = 7'h79;
      default: hex_decode = 7'h71;
    endcase
  endfunction

  // Register file: writes land on the edge that samples BUS_WE.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < NUM_DIGITS; i++) data_r[i] <= '0;
      ctrl_r   <= '0;
      dpmask_r <= '0;
    end else if (BUS_WE) begin
      for (int i = 0; i < NUM_DIGITS; i++)
        if (BUS_ADDR == BASE_ADDR + 8'(i)) data_r[i] <= BUS_DATA;
      if (BUS_ADDR == CTRL_ADDR) ctrl_r   <= BUS_DATA;
      if (BUS_ADDR == DP_ADDR)   dpmask_r <= BUS_DATA;
    end
  end

  assign cnt_wrap = (cnt == CNT_LAST);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      cnt <= '0;
      idx <= '0;
    end else begin
      cnt <= cnt_wrap ? '0 : cnt + 1'b1;
      if (cnt_wrap) idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
    end
  end

`ifdef SEG7_BLINK_EN
  localparam logic [7:0] BLINK_ADDR = BASE_ADDR + 8'(NUM_DIGITS + 2);
  logic [7:0] blinkmask_r;
  logic [5:0] blink_cnt;
  logic       blink_phase;

  // The phase flips on every 64th return of the scan to digit 0.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      blinkmask_r <= '0;
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else begin
      if (BUS_WE && BUS_ADDR == BLINK_ADDR) blinkmask_r <= BUS_DATA;
      if (cnt_wrap && idx == IDX_LAST) begin
        blink_cnt <= blink_cnt + 1'b1;
        if (blink_cnt == 6'd63) blink_phase <= ~blink_phase;
      end
    end
  end
`endif

  always_comb begin
    cur        = data_r[idx];
    seg        = ctrl_r[0] ? cur[6:0] : hex_decode(cur[3:0]);
    digit_next = {dpmask_r[idx], seg};
    sel_next   = NUM_DIGITS'(1) << idx;
`ifdef SEG7_BLINK_EN
    if (blink_phase && blinkmask_r[idx]) digit_next = '0;
`endif
    if (ctrl_r[1]) begin
      sel_next   = '0;
      digit_next = '0;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      SEL   <= ACTIVE_LOW ? '1 : '0;
      DIGIT <= ACTIVE_LOW ? 8'hFF : 8'h00;
    end else begin
      SEL   <= ACTIVE_LOW ? ~sel_next : sel_next;
      DIGIT <= ACTIVE_LOW ? ~digit_next : digit_next;
    end
  end

  // CTRL[7:2] and data bit 7 are stored but have no function.
  assign unused_bits = ^{ctrl_r[7:2], cur[7]};

endmodule

// File: tb/tb_seg7_bus_display.sv
// Directed bench for seg7_bus_display (4 digits, refresh 4, active-low) with a cycle-level
// reference model compared every cycle plus hand-computed literal expectations.
module tb_seg7_bus_display;

  logic       CLK;
  logic       RESET;
  logic       BUS_WE;
  logic [7:0] BUS_ADDR;
  logic [7:0] BUS_DATA;
  logic [3:0] SEL;
  logic [7:0] DIGIT;

  int n_checks = 0;
  int n_fail   = 0;
  bit check_en = 1'b0;

  seg7_bus_display #(
    .NUM_DIGITS (4),
    .BASE_ADDR  (8'hD0),
    .REFRESH_DIV(4),
    .ACTIVE_LOW (1'b1)
  ) dut (
    .CLK     (CLK),
    .RESET   (RESET),
    .BUS_WE  (BUS_WE),
    .BUS_ADDR(BUS_ADDR),
    .BUS_DATA(BUS_DATA),
    .SEL     (SEL),
    .DIGIT   (DIGIT)
  );

  // Clock / reset
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Reference model: m_n counts edges since reset release; the displayed digit is
  // (edges-1)/4 mod 4, computed from register contents before this edge's write.
  logic [6:0] hex_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  logic [7:0] m_reg [6];
  int         m_n   = 0;
  int         m_idx = 0;
  logic [6:0] m_seg;
  logic [3:0] m_sel = 4'hF;
  logic [7:0] m_dig = 8'hFF;

  always @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < 6; i++) m_reg[i] = 8'h00;
      m_n   = 0;
      m_sel = 4'hF;
      m_dig = 8'hFF;
    end else begin
      m_idx = (m_n / 4) % 4;
      m_n++;
      if (m_reg[4][1]) begin
        m_sel = 4'hF;
        m_dig = 8'hFF;
      end else begin
        m_seg = m_reg[4][0] ? m_reg[m_idx][6:0] : hex_tab[m_reg[m_idx][3:0]];
        m_sel = ~(4'b0001 << m_idx);
        m_dig = ~{m_reg[5][m_idx], m_seg};
      end
      if (BUS_WE && BUS_ADDR >= 8'hD0 && BUS_ADDR <= 8'hD5)
        m_reg[BUS_ADDR - 8'hD0] = BUS_DATA;
    end
  end

  // Scoreboard helpers
  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge CLK) begin
    if (check_en) begin
      check8("model_sel", {4'h0, SEL}, {4'h0, m_sel});
      check8("model_digit", DIGIT, m_dig);
    end
  end

  // Driver tasks
  task automatic bus_write(input logic [7:0] addr, input logic [7:0] data);
    BUS_WE   = 1'b1;
    BUS_ADDR = addr;
    BUS_DATA = data;
    @(posedge CLK);
    @(negedge CLK);
    BUS_WE   = 1'b0;
  endtask

  // Wait (bounded) for SEL == target; with fresh set, wait for a new slot start.
  task automatic wait_sel(input logic [3:0] target, input bit fresh);
    bit hit;
    hit = 1'b0;
    if (fresh)
      for (int k = 0; k < 40 && SEL == target; k++) @(negedge CLK);
    for (int k = 0; k < 40; k++) begin
      @(negedge CLK);
      if (SEL == target) begin
        hit = 1'b1;
        break;
      end
    end
    if (!hit) check8("wait_sel_timeout", {4'h0, SEL}, {4'h0, target});
  endtask

  logic [3:0] sel_tab [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  initial begin
    RESET    = 1'b1;
    BUS_WE   = 1'b0;
    BUS_ADDR = 8'h00;
    BUS_DATA = 8'h00;
    check_en = 1'b1;
    repeat (3) @(negedge CLK);
    check8("reset_sel", {4'h0, SEL}, 8'h0F);
    check8("reset_digit", DIGIT, 8'hFF);
    RESET = 1'b0;

    // 1: free-running scan, all digits show hex 0
    for (int k = 0; k < 16; k++) begin
      @(negedge CLK);
      check8("scan_sel", {4'h0, SEL}, {4'h0, sel_tab[k / 4]});
      check8("scan_digit", DIGIT, 8'hC0);
    end

    // 2: hex digits on positions 0 and 3
    bus_write(8'hD0, 8'h05);
    bus_write(8'hD3, 8'h0A);
    wait_sel(4'b1110, 1'b0);
    check8("hex5_digit0", DIGIT, 8'h92);
    wait_sel(4'b0111, 1'b0);
    check8("hexA_digit3", DIGIT, 8'h88);

    // 3: decimal point plus raw mode
    bus_write(8'hD5, 8'h02);
    bus_write(8'hD4, 8'h01);
    bus_write(8'hD1, 8'h49);
    wait_sel(4'b1101, 1'b0);
    check8("raw_dp_digit1", DIGIT, 8'h36);
    wait_sel(4'b1110, 1'b0);
    check8("raw_digit0", DIGIT, 8'hFA);

    // 4: blanking, then resume without rescan from digit 0
    bus_write(8'hD4, 8'h02);
    @(negedge CLK);
    check8("blank_sel", {4'h0, SEL}, 8'h0F);
    check8("blank_digit", DIGIT, 8'hFF);
    repeat (5) @(negedge CLK);
    bus_write(8'hD4, 8'h00);
    @(negedge CLK);
    check8("unblank_one_hot", 8'($countones(~SEL)), 8'd1);

    // 5: write coinciding with the switch to digit 0
    wait_sel(4'b0111, 1'b1);
    repeat (3) @(negedge CLK);
    bus_write(8'hD0, 8'h0F);
    check8("same_edge_sel", {4'h0, SEL}, 8'h0E);
    check8("same_edge_old", DIGIT, 8'h92);
    @(negedge CLK);
    check8("same_edge_new", DIGIT, 8'h8E);
    bus_write(8'hCF, 8'hFF);
    bus_write(8'hD6, 8'hFF);
    wait_sel(4'b1110, 1'b1);
    check8("unmapped_digit0", DIGIT, 8'h8E);
    wait_sel(4'b1101, 1'b0);
    check8("unmapped_digit1", DIGIT, 8'h10);

    // 6: asynchronous reset mid-slot at index 2
    wait_sel(4'b1011, 1'b0);
    #2;
    RESET = 1'b1;
    #1;
    check8("async_reset_sel", {4'h0, SEL}, 8'h0F);
    check8("async_reset_digit", DIGIT, 8'hFF);
    @(negedge CLK);
    RESET = 1'b0;
    @(negedge CLK);
    check8("restart_sel", {4'h0, SEL}, 8'h0E);
    check8("restart_digit0", DIGIT, 8'hC0);
    wait_sel(4'b1101, 1'b0);
    check8("cleared_digit1", DIGIT, 8'hC0);

    repeat (4) @(negedge CLK);
    check_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
